// File: rtl/alloc_search_rr.sv
// Free-entry allocator: busy bit per entry, offers up to two free indices per cycle for dual dispatch.
// Latency: offer is combinational from registered state; alloc/free/flush show in outputs one cycle after the edge.
// Backpressure: o_stall rises when the requests exceed the offers; nothing is committed in a stalled cycle.
// Optional build macro ALLOC_RR_EN: rotating search start (round-robin reuse); undefined = lowest-index-first.
module alloc_search_rr #(
   parameter int ENTSEL = 3,
   parameter int ENTNUM = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_flush,
   input  logic              i_alloc_req0,
   input  logic              i_alloc_req1,
   input  logic [ENTNUM-1:0] i_free_vec,
   output logic [ENTSEL-1:0] o_idx0,
   output logic [ENTSEL-1:0] o_idx1,
   output logic              o_vld0,
   output logic              o_vld1,
   output logic              o_stall,
   output logic [ENTSEL:0]   o_free_cnt
);

   logic [ENTNUM-1:0] r_busy;
   logic [ENTSEL-1:0] w_start;
   logic [ENTSEL:0]   w_scan_pos;
   logic [ENTSEL-1:0] w_idx0;
   logic [ENTSEL-1:0] w_idx1;
   logic              w_vld0;
   logic              w_vld1;
   logic [1:0]        w_need;
   logic [1:0]        w_avail;
   logic              w_stall;
   logic              w_commit;
   logic [ENTNUM-1:0] w_alloc_mask;
   logic [ENTSEL:0]   w_free_cnt;

`ifdef ALLOC_RR_EN
   logic [ENTSEL-1:0] r_ptr;
   logic [ENTSEL-1:0] w_last;

   assign w_start = r_ptr;
   // The slot granted last in this cycle decides where the next search begins.
   assign w_last  = (i_alloc_req0 && i_alloc_req1) ? w_idx1 : w_idx0;
`else
   assign w_start = '0;
`endif

   // Walk all entries once starting at w_start (wrapping at ENTNUM); the first two free ones become the offer.
   always_comb begin
      w_idx0     = '0;
      w_idx1     = '0;
      w_vld0     = 1'b0;
      w_vld1     = 1'b0;
      w_scan_pos = '0;
      for (int k = 0; k < ENTNUM; k++) begin
         w_scan_pos = {1'b0, w_start} + (ENTSEL+1)'(k);
         if (w_scan_pos >= (ENTSEL+1)'(ENTNUM)) begin
            w_scan_pos = w_scan_pos - (ENTSEL+1)'(ENTNUM);
         end
         if (!r_busy[w_scan_pos[ENTSEL-1:0]]) begin
            if (!w_vld0) begin
               w_vld0 = 1'b1;
               w_idx0 = w_scan_pos[ENTSEL-1:0];
            end else if (!w_vld1) begin
               w_vld1 = 1'b1;
               w_idx1 = w_scan_pos[ENTSEL-1:0];
            end
         end
      end
   end

   // Stall when more entries are requested than are on offer; otherwise any request commits.
   assign w_need   = {1'b0, i_alloc_req0} + {1'b0, i_alloc_req1};
   assign w_avail  = {1'b0, w_vld0} + {1'b0, w_vld1};
   assign w_stall  = (w_need > w_avail);
   assign w_commit = (i_alloc_req0 || i_alloc_req1) && !w_stall;

   // First asserted request takes idx0, the second takes idx1, so req1 alone takes idx0.
   always_comb begin
      w_alloc_mask = '0;
      if (w_commit) begin
         if (i_alloc_req0) begin
            w_alloc_mask[w_idx0] = 1'b1;
         end
         if (i_alloc_req1) begin
            if (i_alloc_req0) begin
               w_alloc_mask[w_idx1] = 1'b1;
            end else begin
               w_alloc_mask[w_idx0] = 1'b1;
            end
         end
      end
   end

   // Busy state: reset beats flush beats alloc/free; an alloc overrides a same-cycle free of a non-busy entry.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_busy <= '0;
      end else if (i_flush) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~i_free_vec) | w_alloc_mask;
      end
   end

`ifdef ALLOC_RR_EN
   // Search start advances past the last granted entry on every successful commit.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_ptr <= '0;
      end else if (w_commit) begin
         if (w_last == ENTSEL'(ENTNUM - 1)) begin
            r_ptr <= '0;
         end else begin
            r_ptr <= w_last + ENTSEL'(1);
         end
      end
   end
`endif

   // Count of non-busy entries.
   always_comb begin
      w_free_cnt = '0;
      for (int i = 0; i < ENTNUM; i++) begin
         w_free_cnt = w_free_cnt + {{ENTSEL{1'b0}}, ~r_busy[i]};
      end
   end

   assign o_idx0     = w_idx0;
   assign o_idx1     = w_idx1;
   assign o_vld0     = w_vld0;
   assign o_vld1     = w_vld1;
   assign o_stall    = w_stall;
   assign o_free_cnt = w_free_cnt;

endmodule

// File: tb/tb_alloc_search_rr.sv
module tb_alloc_search_rr;

   localparam int SEL = 3;
   localparam int N   = 8;

   logic           clk;
   logic           reset;
   logic           flush;
   logic           req0;
   logic           req1;
   logic [N-1:0]   free_vec;
   logic [SEL-1:0] idx0;
   logic [SEL-1:0] idx1;
   logic           vld0;
   logic           vld1;
   logic           stall;
   logic [SEL:0]   free_cnt;

   alloc_search_rr #(.ENTSEL(SEL), .ENTNUM(N)) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_flush      (flush),
      .i_alloc_req0 (req0),
      .i_alloc_req1 (req1),
      .i_free_vec   (free_vec),
      .o_idx0       (idx0),
      .o_idx1       (idx1),
      .o_vld0       (vld0),
      .o_vld1       (vld1),
      .o_stall      (stall),
      .o_free_cnt   (free_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int i0;
      int i1;
      bit v0;
      bit v1;
      bit st;
      int cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: a set of busy entries plus the search start.
   bit m_busy[N];
   int m_ptr;

   // Free entries in search order (start, start+1, ... modulo N).
   function automatic void free_list(output int lst[$]);
      lst = {};
      for (int k = 0; k < N; k++) begin
         int p;
         p = (m_ptr + k) % N;
         if (!m_busy[p]) lst.push_back(p);
      end
   endfunction

   function automatic exp_t model_offer(input bit r0, input bit r1);
      exp_t e;
      int   lst[$];
      int   need;
      int   avail;
      free_list(lst);
      e.v0  = lst.size() > 0;
      e.v1  = lst.size() > 1;
      e.i0  = e.v0 ? lst[0] : 0;
      e.i1  = e.v1 ? lst[1] : 0;
      e.cnt = lst.size();
      need  = int'(r0) + int'(r1);
      avail = (lst.size() > 2) ? 2 : lst.size();
      e.st  = need > avail;
      return e;
   endfunction

   // Apply one clock edge with the inputs that were driven during the cycle.
   function automatic void model_edge(input bit rs, input bit fl, input bit r0, input bit r1,
                                      input bit [N-1:0] fv);
      int lst[$];
      int need;
      bit granted[N];
      if (rs || fl) begin
         for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
         m_ptr = 0;
         return;
      end
      for (int i = 0; i < N; i++) granted[i] = 1'b0;
      free_list(lst);
      need = int'(r0) + int'(r1);
      if (need > 0 && need <= lst.size()) begin
         for (int g = 0; g < need; g++) begin
            m_busy[lst[g]]  = 1'b1;
            granted[lst[g]] = 1'b1;
         end
`ifdef ALLOC_RR_EN
         m_ptr = (lst[need-1] + 1) % N;
`endif
      end
      for (int i = 0; i < N; i++) begin
         if (fv[i] && !granted[i]) m_busy[i] = 1'b0;
      end
   endfunction

   // Wait for the edge, advance the model with the inputs just clocked, drive new inputs, queue the expectation.
   task automatic step(input bit rs, input bit fl, input bit r0, input bit r1, input bit [N-1:0] fv);
      @(posedge clk);
      model_edge(reset, flush, req0, req1, free_vec);
      #1;
      reset    = rs;
      flush    = fl;
      req0     = r0;
      req1     = r1;
      free_vec = fv;
      exp_q.push_back(model_offer(r0, r1));
   endtask

   // Directed check of the current cycle against values taken straight from the spec scenarios.
   task automatic chk(input string name, input int e0, input int e1, input bit ev0, input bit ev1,
                      input bit est, input int ecnt);
      @(negedge clk);
      n_tests++;
      if (int'(idx0) != e0 || int'(idx1) != e1 || vld0 != ev0 || vld1 != ev1 ||
          stall != est || int'(free_cnt) != ecnt) begin
         n_fail++;
         $display("FAIL %s: got idx0=%0d idx1=%0d vld=%b%b stall=%b cnt=%0d want idx0=%0d idx1=%0d vld=%b%b stall=%b cnt=%0d",
                  name, idx0, idx1, vld0, vld1, stall, free_cnt, e0, e1, ev0, ev1, est, ecnt);
      end
   endtask

   // Monitor: every cycle with a queued expectation, compare all outputs.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_tests++;
         if (int'(idx0) != e.i0 || int'(idx1) != e.i1 || vld0 != e.v0 || vld1 != e.v1 ||
             stall != e.st || int'(free_cnt) != e.cnt) begin
            n_fail++;
            $display("FAIL scoreboard @%0t: got idx0=%0d idx1=%0d vld=%b%b stall=%b cnt=%0d want idx0=%0d idx1=%0d vld=%b%b stall=%b cnt=%0d",
                     $time, idx0, idx1, vld0, vld1, stall, free_cnt, e.i0, e.i1, e.v0, e.v1, e.st, e.cnt);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, limit 2000000 reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset    = 1'b1;
      flush    = 1'b0;
      req0     = 1'b0;
      req1     = 1'b0;
      free_vec = '0;
      m_ptr    = 0;
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;

      // 1: reset two cycles, then release.
      step(1, 0, 0, 0, '0);
      step(1, 0, 0, 0, '0);
      step(0, 0, 0, 0, '0);
      chk("after_reset", 0, 1, 1, 1, 0, 8);

      // 2: four dual allocations fill the table; a further dual request stalls.
      for (int c = 0; c < 4; c++) step(0, 0, 1, 1, '0);
      step(0, 0, 0, 0, '0);
      chk("full", 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 1, '0);
      chk("full_dual_stall", 0, 0, 0, 0, 1, 0);

      // 3: free entries 2 and 5.
      step(0, 0, 0, 0, 8'h24);
      step(0, 0, 0, 0, '0);
      chk("free_24", 2, 5, 1, 0 == 1 ? 0 : 1, 0, 2);

      // 4: only entry 3 free; dual stalls, then req1 alone takes it.
      step(0, 0, 1, 0, '0);
      step(0, 0, 1, 0, '0);
      step(0, 0, 0, 0, 8'h08);
      step(0, 0, 1, 1, '0);
      chk("one_free_dual_stall", 3, 0, 1, 0, 1, 1);
      step(0, 0, 0, 1, '0);
      chk("one_free_req1", 3, 0, 1, 0, 0, 1);
      step(0, 0, 0, 0, '0);
      chk("one_free_taken", 0, 0, 0, 0, 0, 0);

      // 5: after reset, alloc (0,1) then free both.
      step(1, 0, 0, 0, '0);
      step(0, 0, 1, 1, '0);
      chk("alloc01", 0, 1, 1, 1, 0, 8);
      step(0, 0, 0, 0, 8'h03);
      step(0, 0, 0, 0, '0);
`ifdef ALLOC_RR_EN
      chk("refree01_rr", 2, 3, 1, 1, 0, 8);
`else
      chk("refree01", 0, 1, 1, 1, 0, 8);
`endif

      // 6: five busy, flush with a request and a free; then the same with reset.
      step(1, 0, 0, 0, '0);
      step(0, 0, 1, 1, '0);
      step(0, 0, 1, 1, '0);
      step(0, 0, 1, 0, '0);
      step(0, 1, 1, 0, 8'h01);
      chk("flush_cycle", 5, 6, 1, 1, 0, 3);
      step(0, 0, 0, 0, '0);
      chk("after_flush", 0, 1, 1, 1, 0, 8);
      step(0, 0, 1, 1, '0);
      step(0, 0, 1, 1, '0);
      step(0, 0, 1, 0, '0);
      step(1, 1, 1, 0, 8'h01);
      step(0, 0, 0, 0, '0);
      chk("after_reset_flush", 0, 1, 1, 1, 0, 8);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         bit           rs;
         bit           fl;
         bit [N-1:0]   fv;
         rs = ($urandom_range(0, 299) == 0);
         fl = ($urandom_range(0, 59) == 0);
         fv = '0;
         for (int i = 0; i < N; i++) fv[i] = ($urandom_range(0, 4) == 0);
         step(rs, fl, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), fv);
      end
      step(0, 0, 0, 0, '0);

      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d pending want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
